// File: rtl/iic_reg_seq.sv
// iic_reg_seq: turns single-byte register write/read requests into the
// command stream of a byte-level I2C master (START, byte writes,
// repeated-start preparation, byte read, STOP), then returns read data and
// NACK status to the requester with a one-cycle response pulse.
module iic_reg_seq #(
  parameter logic [3:0] CMD_START     = 4'd1,
  parameter logic [3:0] CMD_WRDATA    = 4'd2,
  parameter logic [3:0] CMD_RDDATA    = 4'd3,
  parameter logic [3:0] CMD_STOP      = 4'd4,
  parameter logic [3:0] CMD_PRE_START = 4'd5
) (
  input  logic       i_SysClock,
  input  logic       i_ResetN,
  // requester side
  input  logic       i_ReqValid,
  output logic       o_ReqReady,
  input  logic       i_ReqRead,
  input  logic [6:0] i_DevAddr,
  input  logic [7:0] i_RegAddr,
  input  logic [7:0] i_WrData,
  output logic       o_RspValid,
  output logic [7:0] o_RspData,
  output logic       o_RspNack,
  // byte-level master side
  output logic       o_CmdValid,
  output logic [3:0] o_Cmd,
  output logic [7:0] o_TxByte,
  output logic       o_SetAck,
  input  logic [7:0] i_RxByte,
  input  logic       i_Done,
  input  logic       i_GetAck
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} seqState_t;

  // One command of the sequence as presented to the master.
  typedef struct packed {
    logic [3:0] cmd;
    logic [7:0] txByte;
    logic       setAck;
  } cmdEntry_t;

  seqState_t  state;
  logic [2:0] step;
  logic       reqRead;
  logic [6:0] devAddr;
  logic [7:0] regAddr;
  logic [7:0] wrData;
  logic       nackFlag;

  logic [2:0] lastStep;
  logic [2:0] nextStep;
  cmdEntry_t  firstEntry;
  cmdEntry_t  nextEntry;

  // Sequence table: the command for a given step of a write or read.
  // The final step of either sequence (and any step past the end) is STOP.
  function automatic cmdEntry_t seqEntry(input logic       isRead,
                                         input logic [6:0] dev,
                                         input logic [7:0] rAddr,
                                         input logic [7:0] wData,
                                         input logic [2:0] idx);
    cmdEntry_t e;
    e.cmd    = CMD_STOP;
    e.txByte = 8'h00;
    e.setAck = 1'b0;
    if (isRead) begin
      case (idx)
        3'd0: e.cmd = CMD_START;
        3'd1: begin e.cmd = CMD_WRDATA; e.txByte = {dev, 1'b0}; end
        3'd2: begin e.cmd = CMD_WRDATA; e.txByte = rAddr;       end
        3'd3: e.cmd = CMD_PRE_START;
        3'd4: e.cmd = CMD_START;
        3'd5: begin e.cmd = CMD_WRDATA; e.txByte = {dev, 1'b1}; end
        3'd6: begin e.cmd = CMD_RDDATA; e.setAck = 1'b1;        end
        default: e.cmd = CMD_STOP;
      endcase
    end else begin
      case (idx)
        3'd0: e.cmd = CMD_START;
        3'd1: begin e.cmd = CMD_WRDATA; e.txByte = {dev, 1'b0}; end
        3'd2: begin e.cmd = CMD_WRDATA; e.txByte = rAddr;       end
        3'd3: begin e.cmd = CMD_WRDATA; e.txByte = wData;       end
        default: e.cmd = CMD_STOP;
      endcase
    end
    return e;
  endfunction

  // Next-step selection: a NACK on a written byte skips straight to STOP.
  always_comb begin
    // NOTE: every always_comb output is assigned before any condition so no
    // path leaves it unassigned (which would infer a latch).
    lastStep = reqRead ? 3'd7 : 3'd4;
    nextStep = step + 3'd1;
    if ((o_Cmd == CMD_WRDATA) && i_GetAck) nextStep = lastStep;
    firstEntry = seqEntry(i_ReqRead, i_DevAddr, i_RegAddr, i_WrData, 3'd0);
    nextEntry  = seqEntry(reqRead, devAddr, regAddr, wrData, nextStep);
  end

  // Sequencer FSM with registered outputs; command fields stay put from
  // ISSUE through the end of WAIT so the master may sample them late.
  always_ff @(posedge i_SysClock or negedge i_ResetN) begin
    if (!i_ResetN) begin
      state      <= IDLE;
      step       <= 3'd0;
      reqRead    <= 1'b0;
      devAddr    <= 7'd0;
      regAddr    <= 8'd0;
      wrData     <= 8'd0;
      nackFlag   <= 1'b0;
      o_ReqReady <= 1'b0;
      o_RspValid <= 1'b0;
      o_RspData  <= 8'd0;
      o_RspNack  <= 1'b0;
      o_CmdValid <= 1'b0;
      o_Cmd      <= 4'd0;
      o_TxByte   <= 8'd0;
      o_SetAck   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register here
      // updates from values sampled at the same clock edge.
      case (state)
        IDLE: begin
          o_RspValid <= 1'b0;
          if (o_ReqReady && i_ReqValid) begin
            reqRead    <= i_ReqRead;
            devAddr    <= i_DevAddr;
            regAddr    <= i_RegAddr;
            wrData     <= i_WrData;
            nackFlag   <= 1'b0;
            step       <= 3'd0;
            o_Cmd      <= firstEntry.cmd;
            o_TxByte   <= firstEntry.txByte;
            o_SetAck   <= firstEntry.setAck;
            o_CmdValid <= i_Done;
            o_ReqReady <= 1'b0;
            state      <= ISSUE;
          end else begin
            o_ReqReady <= 1'b1;
          end
        end
        ISSUE: begin
          if (o_CmdValid) begin
            o_CmdValid <= 1'b0;
            state      <= WAIT;
          end else if (i_Done) begin
            o_CmdValid <= 1'b1;
          end
        end
        WAIT: begin
          if (i_Done) begin
            if (step == lastStep) begin
              o_RspValid <= 1'b1;
              o_RspNack  <= nackFlag;
              state      <= RESP;
            end else begin
              if ((o_Cmd == CMD_WRDATA) && i_GetAck) nackFlag <= 1'b1;
              if (o_Cmd == CMD_RDDATA) o_RspData <= i_RxByte;
              step       <= nextStep;
              o_Cmd      <= nextEntry.cmd;
              o_TxByte   <= nextEntry.txByte;
              o_SetAck   <= nextEntry.setAck;
              o_CmdValid <= i_Done;
              state      <= ISSUE;
            end
          end
        end
        RESP: begin
          o_RspValid <= 1'b0;
          o_ReqReady <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
